// File: rtl/matrix_scan_scheduler_pkg.sv
// Shared constants for the LED matrix scan scheduler: FSM states, layer
// indices, game-over pattern table and win-screen row patterns.
package matrix_scan_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_PLAY = 2'd0;
    localparam state_t ST_OVER = 2'd1;
    localparam state_t ST_WIN  = 2'd2;

    localparam logic [1:0] LAYER_B = 2'd0;
    localparam logic [1:0] LAYER_G = 2'd1;
    localparam logic [1:0] LAYER_R = 2'd2;

    localparam logic [7:0] ALL_OFF  = 8'hFF;
    localparam logic [7:0] WIN_EVEN = 8'h55;
    localparam logic [7:0] WIN_ODD  = 8'hAA;

    // Active-low cross drawn on the red plane while the game is over
    localparam logic [7:0] OVER_PATTERN [0:7] = '{
        8'h7E, 8'hBD, 8'hDB, 8'hE7, 8'hE7, 8'hDB, 8'hBD, 8'h7E
    };

    function automatic logic [7:0] over_row(input logic [2:0] row);
        return OVER_PATTERN[row];
    endfunction

endpackage

// File: rtl/matrix_scan_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter; the pointer remembers the last granted
// request and the search starts just after it.
module rr_arbiter3
    import matrix_scan_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       advance,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_idx,
    output logic [1:0] ptr
);

    logic [1:0] ptr_r;
    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    assign ptr = ptr_r;

    // Search order derived from the last granted layer
    always_comb begin
        first_s  = LAYER_B;
        second_s = LAYER_G;
        third_s  = LAYER_R;
        case (ptr_r)
            LAYER_B: begin
                first_s  = LAYER_G;
                second_s = LAYER_R;
                third_s  = LAYER_B;
            end
            LAYER_G: begin
                first_s  = LAYER_R;
                second_s = LAYER_B;
                third_s  = LAYER_G;
            end
            default: begin
                first_s  = LAYER_B;
                second_s = LAYER_G;
                third_s  = LAYER_R;
            end
        endcase
    end

    // Pick the first requesting layer in search order
    always_comb begin
        grant_valid = 1'b1;
        grant_idx   = first_s;
        if (req[first_s]) begin
            grant_idx = first_s;
        end else if (req[second_s]) begin
            grant_idx = second_s;
        end else if (req[third_s]) begin
            grant_idx = third_s;
        end else begin
            grant_valid = 1'b0;
            grant_idx   = ptr_r;
        end
        grant = grant_valid ? (3'b001 << grant_idx) : 3'b000;
    end

    // Pointer moves only when a grant is actually taken
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr_r <= LAYER_R;
        end else if (advance && grant_valid) begin
            ptr_r <= grant_idx;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/matrix_scan_scheduler.sv
// Display slot scheduler for an 8x8 RGB matrix: round-robin over three
// colour layers while playing, fixed screens for game-over and win.
module matrix_scan_scheduler
    import matrix_scan_scheduler_pkg::*;
#(
    parameter int BLANK = 2
)
(
    input  logic       CLK,
    input  logic       Clear,
    input  logic       scan_tick,
    input  logic [7:0] b_data,
    input  logic [7:0] g_data,
    input  logic [7:0] r_data,
    input  logic [2:0] b_row,
    input  logic [2:0] g_row,
    input  logic [2:0] r_row,
    input  logic       b_valid,
    input  logic       g_valid,
    input  logic       r_valid,
    input  logic       game_over,
    input  logic       win,
    output logic [2:0] ack,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [2:0] S,
    output logic       COMM,
    output logic       frame_done
);

    localparam logic [3:0] BLANK_CNT = 4'(BLANK);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] row_r;
    logic [2:0] row_nxt_s;
    logic [3:0] blank_r;
    logic       prev_wrap_r;
    logic [7:0] slot_red_r, slot_green_r, slot_blue_r;
    logic [2:0] slot_row_r;
    logic [7:0] slot_red_s, slot_green_s, slot_blue_s;
    logic [2:0] slot_row_s;
    logic [7:0] out_red_r, out_green_r, out_blue_r;
    logic [2:0] out_row_r;
    logic       play_tick_s;
    logic [2:0] grant_s;
    logic       grant_valid_s;
    logic [1:0] grant_idx_s;
    logic [1:0] ptr_s;

    assign play_tick_s = scan_tick && !Clear && (state_r == ST_PLAY)
                         && !game_over && !win;

    rr_arbiter3 u_arb (
        .clk         (CLK),
        .clear       (Clear),
        .advance     (play_tick_s),
        .req         ({r_valid, g_valid, b_valid}),
        .grant       (grant_s),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s),
        .ptr         (ptr_s)
    );

    assign DATA_R = out_red_r;
    assign DATA_G = out_green_r;
    assign DATA_B = out_blue_r;
    assign S      = out_row_r;
    assign COMM   = 1'b1;

    // Grant strobe and frame marker belong to the scan_tick cycle itself
    always_comb begin
        ack        = 3'b000;
        frame_done = 1'b0;
        if (play_tick_s) begin
            ack        = grant_s;
            frame_done = grant_valid_s && (grant_idx_s == LAYER_B) && prev_wrap_r;
        end else if (scan_tick && !Clear && (state_r != ST_PLAY)) begin
            frame_done = (row_r == 3'd7);
        end else begin
            ack        = 3'b000;
            frame_done = 1'b0;
        end
    end

    // Next state and the slot content to be latched on this scan_tick
    always_comb begin
        state_nxt_s  = state_r;
        row_nxt_s    = row_r;
        slot_red_s   = ALL_OFF;
        slot_green_s = ALL_OFF;
        slot_blue_s  = ALL_OFF;
        slot_row_s   = 3'd0;
        case (state_r)
            ST_PLAY: begin
                if (game_over) begin
                    state_nxt_s = ST_OVER;
                    row_nxt_s   = 3'd0;
                    slot_red_s  = over_row(3'd0);
                end else if (win) begin
                    state_nxt_s  = ST_WIN;
                    row_nxt_s    = 3'd0;
                    slot_green_s = WIN_EVEN;
                end else if (grant_valid_s) begin
                    case (grant_idx_s)
                        LAYER_B: begin
                            slot_blue_s = ~b_data;
                            slot_row_s  = b_row;
                        end
                        LAYER_G: begin
                            slot_green_s = ~g_data;
                            slot_row_s   = g_row;
                        end
                        LAYER_R: begin
                            slot_red_s = ~r_data;
                            slot_row_s = r_row;
                        end
                        default: begin
                            slot_row_s = 3'd0;
                        end
                    endcase
                end else begin
                    slot_row_s = 3'd0;
                end
            end
            ST_OVER: begin
                row_nxt_s  = row_r + 3'd1;
                slot_red_s = over_row(row_nxt_s);
                slot_row_s = row_nxt_s;
            end
            ST_WIN: begin
                row_nxt_s    = row_r + 3'd1;
                slot_green_s = row_nxt_s[0] ? WIN_ODD : WIN_EVEN;
                slot_row_s   = row_nxt_s;
            end
            default: begin
                state_nxt_s = ST_PLAY;
            end
        endcase
    end

    // Slot latch, blanking counter and registered matrix drive
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_r      <= ST_PLAY;
            row_r        <= 3'd0;
            blank_r      <= 4'd0;
            prev_wrap_r  <= 1'b0;
            slot_red_r   <= ALL_OFF;
            slot_green_r <= ALL_OFF;
            slot_blue_r  <= ALL_OFF;
            slot_row_r   <= 3'd0;
            out_red_r    <= ALL_OFF;
            out_green_r  <= ALL_OFF;
            out_blue_r   <= ALL_OFF;
            out_row_r    <= 3'd0;
        end else if (scan_tick) begin
            state_r      <= state_nxt_s;
            row_r        <= row_nxt_s;
            blank_r      <= 4'd0;
            slot_red_r   <= slot_red_s;
            slot_green_r <= slot_green_s;
            slot_blue_r  <= slot_blue_s;
            slot_row_r   <= slot_row_s;
            if (play_tick_s) begin
                prev_wrap_r <= !grant_valid_s || (grant_idx_s == LAYER_R);
            end else begin
                prev_wrap_r <= prev_wrap_r;
            end
            if (BLANK_CNT == 4'd0) begin
                out_red_r   <= slot_red_s;
                out_green_r <= slot_green_s;
                out_blue_r  <= slot_blue_s;
                out_row_r   <= slot_row_s;
            end else begin
                out_red_r   <= ALL_OFF;
                out_green_r <= ALL_OFF;
                out_blue_r  <= ALL_OFF;
                out_row_r   <= 3'd0;
            end
        end else if (blank_r != BLANK_CNT) begin
            blank_r <= blank_r + 4'd1;
            // The last blanking cycle loads the slot so it appears right after
            if ((blank_r + 4'd1) == BLANK_CNT) begin
                out_red_r   <= slot_red_r;
                out_green_r <= slot_green_r;
                out_blue_r  <= slot_blue_r;
                out_row_r   <= slot_row_r;
            end else begin
                out_red_r   <= ALL_OFF;
                out_green_r <= ALL_OFF;
                out_blue_r  <= ALL_OFF;
                out_row_r   <= 3'd0;
            end
        end else begin
            out_red_r   <= slot_red_r;
            out_green_r <= slot_green_r;
            out_blue_r  <= slot_blue_r;
            out_row_r   <= slot_row_r;
        end
    end

endmodule

// File: doc/matrix_scan_scheduler.md
MATRIX_SCAN_SCHEDULER -- requirements
Module: matrix_scan_scheduler

Interface
REQ-001 Parameter BLANK, default 2: blanking cycles inserted after every scan_tick before new data is driven (range 0..15).
REQ-002 CLK  in  1  single system clock; all logic on rising edge.
REQ-003 Clear  in  1  reset, synchronous, active-high.
REQ-004 scan_tick  in  1  one-CLK strobe from the display divider; starts one display slot.
REQ-005 b_data, g_data, r_data  in  8 each  layer row pixels, active-high (1 = lit).
REQ-006 b_row, g_row, r_row  in  3 each  row select belonging to each layer's data.
REQ-007 b_valid, g_valid, r_valid  in  1 each  layer has a row to show.
REQ-008 game_over, win  in  1 each  level-sensitive game status.
REQ-009 ack  out  3  one-CLK grant pulse, bit0=B, bit1=G, bit2=R.
REQ-010 DATA_R, DATA_G, DATA_B  out  8 each  matrix colour drive, active-low (1 = off).
REQ-011 S  out  3  row select to matrix.
REQ-012 COMM  out  1  common enable; constant 1.
REQ-013 frame_done  out  1  one-CLK pulse at end of each full scan.

Function
REQ-014 FSM states PLAY, OVER, WIN; OVER and WIN leave only via Clear.
REQ-015 PLAY->OVER when game_over=1 on a scan_tick cycle; PLAY->WIN when win=1 and game_over=0 on a scan_tick cycle; game_over has priority.
REQ-016 PLAY: on scan_tick, round-robin over order B,G,R starting after the last granted layer; invalid layers skipped.
REQ-017 Granted layer receives ack pulse in the scan_tick cycle; its data/row are latched in that same edge.
REQ-018 No layer valid on scan_tick: no ack, pointer unchanged, slot shows all-off (DATA_*=8'hFF), S=0.
REQ-019 After scan_tick edge, DATA_R/G/B=8'hFF for BLANK cycles, then granted layer's latched data inverted on its own colour, other colours 8'hFF, S = latched row; held until next scan_tick.
REQ-020 BLANK=0: latched data appears in the cycle following the scan_tick edge.
REQ-021 scan_tick during an active blanking count restarts the count and performs a new grant.
REQ-022 PLAY frame_done pulses when pointer wraps from R back to B (a grant of B following a grant of R or of nothing).
REQ-023 OVER: row counter 0..7 advances per scan_tick; DATA_R row pattern 7E,BD,DB,E7,E7,DB,BD,7E (active-low), G/B=8'hFF, S=row; frame_done on 7->0 wrap; ack=0.
REQ-024 WIN: same row counter; DATA_G = 8'h55 on even rows, 8'hAA on odd rows, R/B=8'hFF, S=row; ack=0.
REQ-025 Entering OVER/WIN resets row counter to 0; first row shown after BLANK cycles.
REQ-026 Blank counter 4 bits, saturates at BLANK; row counter 3 bits, wraps 7->0.
REQ-027 Layer inputs changing after latch have no effect until next grant.

Reset
REQ-028 Clear=1 at an edge: state PLAY, pointer = R (first grant B), row counter 0, blank counter 0, DATA_R/G/B=8'hFF, S=0, ack=0, frame_done=0, COMM=1.
REQ-029 Clear overrides scan_tick in the same cycle; no ack issued.
REQ-030 Clear mid-blanking or mid-slot returns outputs to all-off the following cycle.

Structure
REQ-031 Shared package holds state enum (PLAY, OVER, WIN), layer index constants (B=0, G=1, R=2), the 8-entry OVER pattern table and the two WIN row constants.
REQ-032 One sub-module, rr_arbiter3: 3-request round-robin with pointer, one-hot grant, grant-valid.

Verification
REQ-033 Reset, all valid, 4 scan_ticks, BLANK=2 -> ack 001,010,100,001; DATA_B=~b_data after 2 blank cycles; frame_done with 4th ack.
REQ-034 Only g_valid, g_data=8'h81, g_row=5 -> ack 010 every tick; DATA_G=8'h7E, S=5, R/B=8'hFF.
REQ-035 No valid, scan_tick -> ack 000, all DATA 8'hFF, S=0.
REQ-036 game_over=1 and win=1 on same tick -> OVER; 8 ticks yield S=0..7 with DATA_R 7E..7E table; frame_done on wrap; ack never set.
REQ-037 Clear asserted same cycle as scan_tick in WIN -> next cycle PLAY, outputs 8'hFF, ack 000; next tick grants B.
REQ-038 Second scan_tick 1 cycle after first (BLANK=2) -> blank restarts, second layer shown 2 cycles later.
